// File: rtl/dlf16_pkg.sv
// dlf16_pkg: DLFloat16 pre-round word layout, rounding modes and mode check
package dlf16_pkg;
    localparam int EXP_W  = 6;
    localparam int MANT_W = 9;
    localparam int GRS_W  = 4;
    localparam int RM_W   = 3;
    localparam int RES_W  = 1 + EXP_W + MANT_W;
    localparam int PRE_W  = RES_W + GRS_W;

    localparam logic [RM_W-1:0] RM_RNE = 3'b000;
    localparam logic [RM_W-1:0] RM_RTZ = 3'b001;
    localparam logic [RM_W-1:0] RM_RUP = 3'b010;
    localparam logic [RM_W-1:0] RM_RDN = 3'b011;

    // sign at bit 19, exp 18:13, mant 12:4, guard/round/sticky bits 3:0
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic [GRS_W-1:0]  grs;
    } pre_word_t;

    function automatic logic rm_legal(input logic [RM_W-1:0] rm);
        return rm <= RM_RDN;
    endfunction
endpackage

// File: rtl/fp_round_arbiter_rr.sv
// rr_arbiter: round-robin one-hot grant with a pointer that advances past each accepted winner
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_advance,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx
);
    logic [IDW-1:0] r_ptr;

    // lowest requester at or above ptr wins, otherwise the lowest requester overall
    always_comb begin
        o_idx = '0;
        for (int j = NREQ - 1; j >= 0; j--) if (i_req[j]) o_idx = IDW'(j);
        for (int j = NREQ - 1; j >= 0; j--) if (i_req[j] && IDW'(j) >= r_ptr) o_idx = IDW'(j);
        o_grant = (|i_req) ? (NREQ'(1) << o_idx) : '0;
    end

    // pointer moves to the slot after the winner only when the grant is taken
    always_ff @(posedge clk) begin
        if (rst) r_ptr <= '0;
        else if (i_advance) r_ptr <= (o_idx == IDW'(NREQ - 1)) ? '0 : o_idx + 1'b1;
    end
endmodule

// File: rtl/fp_round_arbiter.sv
// fp_round_arbiter: shares one registered DLFloat16 rounding unit among NREQ producers with credit-gated result FIFO
module fp_round_arbiter
    import dlf16_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int DEPTH = 2,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*PRE_W-1:0] req_data,
    input  logic [NREQ*RM_W-1:0]  req_rm,
    output logic [PRE_W-1:0]      ru_in1,
    output logic [RM_W-1:0]       ru_rm,
    input  logic [RES_W-1:0]      ru_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [RES_W-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_idx;
    logic             w_accept, w_pop, w_issue_ok, w_legal;
    pre_word_t        w_sel;
    logic [RM_W-1:0]  w_sel_rm;

    logic [PRE_W-1:0] r_last_in1;
    logic [RM_W-1:0]  r_last_rm;
    logic             r_inf_v, r_inf_err;
    logic [IDW-1:0]   r_inf_id;

    logic [RES_W-1:0] r_data [DEPTH];
    logic [IDW-1:0]   r_id   [DEPTH];
    logic             r_err  [DEPTH];
    logic [PW-1:0]    r_wr, r_rd;
    logic [CW-1:0]    r_count;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .i_req     (req_valid),
        .i_advance (w_accept),
        .o_grant   (w_grant),
        .o_idx     (w_idx)
    );

    // credit check counts FIFO entries plus the in-flight slot, with a same-cycle pop returning a credit
    always_comb begin
        rsp_valid  = r_count != '0;
        w_pop      = rsp_valid & rsp_ready;
        w_issue_ok = ({1'b0, r_count} + (CW+1)'(r_inf_v) - (CW+1)'(w_pop)) < (CW+1)'(DEPTH);
        req_ready  = w_grant & {NREQ{w_issue_ok & ~rst}};
        w_accept   = |req_ready;
        w_sel      = req_data[PRE_W*w_idx +: PRE_W];
        w_sel_rm   = req_rm[RM_W*w_idx +: RM_W];
        w_legal    = rm_legal(w_sel_rm);
        ru_in1     = w_accept ? w_sel : r_last_in1;
        ru_rm      = w_accept ? (w_legal ? w_sel_rm : RM_RNE) : r_last_rm;
        rsp_data   = rsp_valid ? r_data[r_rd] : '0;
        rsp_id     = rsp_valid ? r_id[r_rd] : '0;
        rsp_err    = rsp_valid ? r_err[r_rd] : 1'b0;
    end

    // issue hold registers and the one-deep tag stage matching the rounding unit latency
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_in1 <= '0;
            r_last_rm  <= '0;
            r_inf_v    <= 1'b0;
            r_inf_id   <= '0;
            r_inf_err  <= 1'b0;
        end else begin
            r_inf_v   <= w_accept;
            r_inf_id  <= w_idx;
            r_inf_err <= w_accept & ~w_legal;
            if (w_accept) begin
                r_last_in1 <= ru_in1;
                r_last_rm  <= ru_rm;
            end
        end
    end

    // result FIFO: capture ru_out with its tag one cycle after issue, drain from head on pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            assert (!r_inf_v || w_pop || r_count != CW'(DEPTH));
            if (r_inf_v) begin
                r_data[r_wr] <= ru_out;
                r_id[r_wr]   <= r_inf_id;
                r_err[r_wr]  <= r_inf_err;
                r_wr         <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
            end
            if (w_pop) r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
            r_count <= r_count + CW'(r_inf_v) - CW'(w_pop);
        end
    end
endmodule

// File: tb/tb_fp_round_arbiter.sv
// tb_fp_round_arbiter: directed vector table and multi-cycle sequences for the shared rounding arbiter
module tb_fp_round_arbiter;
    import dlf16_pkg::*;

    localparam int NREQ = 3;
    localparam int DEPTH = 2;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*20-1:0] req_data;
    logic [NREQ*3-1:0] req_rm;
    logic [19:0]       ru_in1;
    logic [2:0]        ru_rm;
    logic [15:0]       ru_out;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [15:0]       rsp_data;
    logic [IDW-1:0]    rsp_id;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fp_round_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_rm    (req_rm),
        .ru_in1    (ru_in1),
        .ru_rm     (ru_rm),
        .ru_out    (ru_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err)
    );

    // behavioural registered rounding unit standing in for the real one
    function automatic logic [15:0] round_unit(input logic [19:0] w, input logic [2:0] rm);
        logic any_grs;
        logic inc;
        any_grs = |w[3:0];
        inc = (rm == RM_RNE) ? (w[3] & ((|w[2:0]) | w[4])) :
              (rm == RM_RUP) ? (~w[19] & any_grs) :
              (rm == RM_RDN) ? (w[19] & any_grs) : 1'b0;
        return {w[19], w[18:4] + 15'(inc)};
    endfunction

    always_ff @(posedge clk) ru_out <= rst ? 16'h0 : round_unit(ru_in1, ru_rm);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int id, input logic [19:0] d, input logic [2:0] rm);
        req_data[20*id +: 20] = d;
        req_rm[3*id +: 3] = rm;
    endtask

    typedef struct {
        int          id;
        logic [19:0] d;
        logic [2:0]  rm;
        logic [2:0]  xrm;
        logic [15:0] xd;
        logic        xerr;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        req_valid = '0;
        drive(v.id, v.d, v.rm);
        req_valid[v.id] = 1'b1;
        #1;
        chk("vec_accept", 32'(req_ready), 32'(1) << v.id);
        chk("vec_ru_in1", 32'(ru_in1), 32'(v.d));
        chk("vec_ru_rm", 32'(ru_rm), 32'(v.xrm));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("vec_lat_t1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("vec_valid_t2", 32'(rsp_valid), 32'd1);
        chk("vec_data", 32'(rsp_data), 32'(v.xd));
        chk("vec_id", 32'(rsp_id), 32'(v.id));
        chk("vec_err", 32'(rsp_err), 32'(v.xerr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int pops;
        vecs[0] = '{0, {1'b0, 6'd31, 9'h0AB, 4'b0111}, 3'b001, 3'b001, 16'h3EAB, 1'b0};
        vecs[1] = '{2, {1'b0, 6'd31, 9'h0AB, 4'b0111}, 3'b101, 3'b000, 16'h3EAB, 1'b1};
        vecs[2] = '{1, {1'b0, 6'd31, 9'h1FF, 4'b1000}, 3'b010, 3'b010, 16'h4000, 1'b0};
        vecs[3] = '{0, {1'b0, 6'd31, 9'h0AB, 4'b1000}, 3'b000, 3'b000, 16'h3EAC, 1'b0};
        vecs[4] = '{1, {1'b1, 6'd31, 9'h0AB, 4'b0001}, 3'b011, 3'b011, 16'hBEAC, 1'b0};
        vecs[5] = '{2, {1'b1, 6'd31, 9'h0AB, 4'b0001}, 3'b010, 3'b010, 16'hBEAB, 1'b0};
        vecs[6] = '{1, {1'b0, 6'd31, 9'h0AB, 4'b1100}, 3'b111, 3'b000, 16'h3EAC, 1'b1};
        vecs[7] = '{0, {1'b0, 6'd31, 9'h0AA, 4'b1000}, 3'b000, 3'b000, 16'h3EAA, 1'b0};

        rsp_ready = 1'b1;
        req_data = '0;
        req_rm = '0;
        for (int i = 0; i < NREQ; i++) drive(i, {1'b0, 6'd31, 9'(i), 4'b0000}, RM_RTZ);
        req_valid = 3'b111;
        @(negedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);

        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(1) << (k % 3));
            if (k >= 2) begin
                chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rr_rsp_id", 32'(rsp_id), 32'((k - 2) % 3));
                chk("rr_rsp_data", 32'(rsp_data), 32'h3E00 + 32'((k - 2) % 3));
            end
            @(negedge clk);
        end
        req_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rr_drained", 32'(rsp_valid), 32'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        @(negedge clk);
        rsp_ready = 1'b0;
        drive(1, {1'b0, 6'd31, 9'h055, 4'b0000}, RM_RTZ);
        req_valid = 3'b010;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (req_ready == 3'b010) acc++;
            @(negedge clk);
        end
        #1;
        chk("bp_accepts", 32'(acc), 32'd2);
        chk("bp_blocked", 32'(req_ready), 32'd0);
        chk("bp_head_valid", 32'(rsp_valid), 32'd1);
        chk("bp_head_id", 32'(rsp_id), 32'd1);
        chk("bp_head_data", 32'(rsp_data), 32'h3E55);
        rsp_ready = 1'b1;
        #1;
        chk("bp_pop_frees_credit", 32'(req_ready), 32'b010);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("bp_full_again", 32'(req_ready), 32'd0);
        chk("bp_still_valid", 32'(rsp_valid), 32'd1);
        req_valid = '0;
        rsp_ready = 1'b1;
        pops = 0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid) pops++;
            @(negedge clk);
            #1;
        end
        chk("bp_remaining_pops", 32'(pops), 32'd2);

        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 3'b010;
        repeat (2) @(negedge clk);
        #1;
        chk("mid_pre_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        drive(0, {1'b0, 6'd31, 9'h012, 4'b0000}, RM_RTZ);
        req_valid = 3'b111;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rsp_cleared", 32'(rsp_valid), 32'd0);
        chk("mid_ptr_reset", 32'(req_ready), 32'b001);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("mid_no_late_capture", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("mid_new_valid", 32'(rsp_valid), 32'd1);
        chk("mid_new_id", 32'(rsp_id), 32'd0);
        chk("mid_new_data", 32'(rsp_data), 32'h3E12);
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_final_empty", 32'(rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_round_arbiter.md
Name: fp_round_arbiter

Overview:
- Shares one registered DLFloat16 rounding unit among NREQ producers (adder, multiplier, converter).
- Producers present pre-rounded words {sign, exp[5:0], mant[8:0], G, R, S1, S2} plus a rounding mode.
- The arbiter grants one producer per cycle, round-robin, and issues the word to the rounding unit. Issue is credit-gated against an output result FIFO.
- It tracks the rounding unit's 1-cycle latency, captures each rounded 16-bit result and returns it, tagged with the requester id, on a single valid/ready response channel.

Parameters:
NREQ, 3, number of requesters (2..8)
DEPTH, 2, result FIFO entries (>=2 for full throughput)
IDW, $clog2(NREQ), derived; width of requester id

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_data  in  NREQ*20  packed pre-round words, requester i at [20*i+19:20*i]
req_rm  in  NREQ*3  packed rounding modes
ru_in1  out  20  to rounding unit data input
ru_rm  out  3  to rounding unit mode input
ru_out  in  16  registered rounding unit result
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  16  rounded DLFloat16 result
rsp_id  out  IDW  index of originating requester
rsp_err  out  1  request carried an illegal rounding mode

Behaviour:
- Reset values:
  - rsp_valid=0; rsp_data=0; rsp_id=0; rsp_err=0.
  - req_ready=0 during the reset cycle.
  - Round-robin pointer=0; inflight=0; FIFO count=0, rd/wr pointers 0.
- Credit and pop:
  - pop = rsp_valid & rsp_ready.
  - issue_ok = (count + inflight - pop) < DEPTH.
  - A same-cycle pop frees a credit.
- Arbitration (combinational):
  - Grant goes to the first i with req_valid[i], scanning from ptr upward with wrap mod NREQ.
  - req_ready[i] = grant[i] & issue_ok & ~rst. At most one bit is set.
- Issue:
  - On accept, ru_in1 = selected req_data and ru_rm = selected req_rm in the same cycle.
  - When idle, ru_in1 and ru_rm hold the last issued value.
  - ptr <= (granted index + 1) mod NREQ. The pointer moves only on accept.
- Illegal mode:
  - Legal modes are 000 RNE, 001 RTZ, 010 RUP, 011 RDN.
  - rm > 3'b011 is driven to ru_rm as 000, and the err bit is carried with the transaction.
- In-flight stage:
  - One-entry pipeline register {valid, id, err} set on accept, otherwise cleared.
  - One cycle after accept, ru_out is written into the FIFO with that id/err.
  - Exactly one result per accepted request.
- Latency:
  - Accept at cycle t gives ru_out valid at t+1, FIFO write at the end of t+1, rsp_valid at t+2.
  - Sustained throughput is 1/cycle when rsp_ready=1 and DEPTH>=2.
- FIFO:
  - Circular buffer, DEPTH entries of {data16, id, err}.
  - Push and pop in the same cycle leave count unchanged.
  - Credit gating guarantees a push never hits a full FIFO. Overflow is an assertion.
  - rsp_* reflect the head entry and hold stable while rsp_valid & ~rsp_ready.
- Ordering: responses return strictly in accept order.
- Reset mid-operation:
  - The in-flight entry and FIFO contents are discarded.
  - A result arriving on ru_out in the cycle after reset is not captured.
  - The rounding unit's active-low reset is tied to ~rst at integration.
- Requester-side rules:
  - req_data and req_rm must hold while req_valid & ~req_ready.
  - A requester dropping valid unaccepted is tolerated; it is not checked.

Decomposition:
- Shared package dlf16_pkg:
  - Field widths and offsets: sign bit 19, exp 18:13, mant 12:4, GRS 3:0.
  - RM_RNE/RM_RTZ/RM_RUP/RM_RDN constants and a legal-mode check function.
- One sub-module: rr_arbiter (NREQ request vector, ptr, advance strobe, one-hot grant).
- The FIFO stays inline.

Test Plan:
1. Single request, requester 0: in1={0,6'd31,9'h0AB,4'b0111}, rm=001. Expect accept at t; rsp_valid at t+2 with rsp_data=16'h3EAB, rsp_id=0, rsp_err=0.
2. All three requesters valid continuously from reset, rsp_ready=1. Expect grants 0,1,2,0,... on consecutive cycles and rsp_id sequence 0,1,2,0 with no bubbles.
3. rsp_ready=0 with requester 1 valid, DEPTH=2. Expect exactly two accepts, then req_ready=0. Pulse rsp_ready for one cycle: one pop and a new accept in that same cycle; count stays 2.
4. Illegal mode rm=3'b101 on requester 2. Expect ru_rm=000 at issue; response carries rsp_err=1, rsp_id=2.
5. RUP with carry: in1={0,6'd31,9'h1FF,4'b1000}, rm=010. Expect rsp_data=16'h4000 (mantissa overflow increments exp).
6. Reset mid-operation: rst=1 for one cycle with one entry in flight and one in the FIFO. Expect rsp_valid=0 next cycle, no late capture, and the next grant goes to requester 0.
